// File: rtl/hero_anim_sequencer.sv
// -----------------------------------------------------------------------------
// hero_anim_sequencer
//
// Per-frame animation controller for the hero sprite. Once per video frame
// (frame_tick) it picks the sprite ROM to display (idle, a running frame or
// jump), the horizontal mirror flag and the vertical jump offset. Every state
// change happens only on a frame_tick cycle, so nothing changes mid-scan.
//
// Parameters:
//   RUN_FRAMES       number of running frames (2..5)
//   TICKS_PER_FRAME  frame ticks each running frame is held (1..15)
//   JUMP_V           initial upward velocity, pixels per tick (1..15)
//
// Ports:
//   vga_clk      in   pixel clock, the only clock
//   reset_n      in   asynchronous active-low reset
//   frame_tick   in   single-cycle pulse at vsync start
//   move_left    in   level, sampled on frame_tick
//   move_right   in   level, sampled on frame_tick
//   jump_req     in   level, sampled on frame_tick
//   sprite_sel   out  0 idle, 1..RUN_FRAMES running frame, 6 jump
//   facing_left  out  1 = mirror sprite horizontally
//   y_offset     out  unsigned pixels above ground
//   airborne     out  1 while jumping
// -----------------------------------------------------------------------------
module hero_anim_sequencer #(
   parameter int RUN_FRAMES      = 5,
   parameter int TICKS_PER_FRAME = 6,
   parameter int JUMP_V          = 8
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       move_left,
   input  logic       move_right,
   input  logic       jump_req,
   output logic [2:0] sprite_sel,
   output logic       facing_left,
   output logic [6:0] y_offset,
   output logic       airborne
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      JUMP = 2'd2
   } state_t;

   localparam logic [2:0] RUN_LAST   = 3'(RUN_FRAMES - 1);
   localparam logic [3:0] DIV_LAST   = 4'(TICKS_PER_FRAME - 1);
   localparam logic [6:0] JUMP_Y0    = 7'(JUMP_V);
   localparam logic [5:0] JUMP_VY0   = 6'(JUMP_V - 1);
   localparam logic [2:0] SPRITE_JMP = 3'd6;

   state_t             state;
   logic [2:0]         run_idx;
   logic [3:0]         div;
   logic signed [5:0]  vy;
   logic [6:0]         y_off;

   logic               moving;
   logic [2:0]         run_idx_adv;
   logic signed [7:0]  jump_sum;
   logic               landing;

   assign moving = move_left ^ move_right;

   // Next running frame index when the hold counter expires, with wrap.
   assign run_idx_adv = (run_idx == RUN_LAST) ? 3'd0 : run_idx + 3'd1;

   // Height plus velocity evaluated as signed; 8 bits covers 0..127 plus
   // the most negative velocity without overflow.
   assign jump_sum = $signed({1'b0, y_off}) + $signed({{2{vy[5]}}, vy});
   assign landing  = jump_sum[7] || (jump_sum == 8'sd0);

   // y_off is itself a flop, so the offset output is driven straight from it.
   assign y_offset = y_off;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         run_idx     <= 3'd0;
         div         <= 4'd0;
         vy          <= 6'sd0;
         y_off       <= 7'd0;
         sprite_sel  <= 3'd0;
         facing_left <= 1'b0;
         airborne    <= 1'b0;
      end else if (frame_tick) begin
         // Direction latches whenever exactly one direction is held,
         // regardless of state (mid-air turns are allowed).
         if (moving) begin
            facing_left <= move_left;
         end

         case (state)
            IDLE, RUN: begin
               if (jump_req) begin
                  state      <= JUMP;
                  y_off      <= JUMP_Y0;
                  vy         <= JUMP_VY0;
                  sprite_sel <= SPRITE_JMP;
                  airborne   <= 1'b1;
               end else if (!moving) begin
                  state      <= IDLE;
                  run_idx    <= 3'd0;
                  div        <= 4'd0;
                  sprite_sel <= 3'd0;
               end else if (state == IDLE) begin
                  state      <= RUN;
                  run_idx    <= 3'd0;
                  div        <= 4'd0;
                  sprite_sel <= 3'd1;
               end else if (div == DIV_LAST) begin
                  div        <= 4'd0;
                  run_idx    <= run_idx_adv;
                  sprite_sel <= run_idx_adv + 3'd1;
               end else begin
                  div        <= div + 4'd1;
               end
            end

            JUMP: begin
               // jump_req is deliberately ignored here: no double jump,
               // and a held request only restarts after landing.
               if (landing) begin
                  y_off      <= 7'd0;
                  vy         <= 6'sd0;
                  run_idx    <= 3'd0;
                  div        <= 4'd0;
                  airborne   <= 1'b0;
                  state      <= moving ? RUN : IDLE;
                  sprite_sel <= moving ? 3'd1 : 3'd0;
               end else begin
                  y_off      <= jump_sum[6:0];
                  vy         <= vy - 6'sd1;
               end
            end

            default: begin
               state      <= IDLE;
               run_idx    <= 3'd0;
               div        <= 4'd0;
               vy         <= 6'sd0;
               y_off      <= 7'd0;
               sprite_sel <= 3'd0;
               airborne   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hero_anim_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hero_anim_sequencer
//
// Self-checking bench for hero_anim_sequencer with default parameters.
// The reference model tracks the hero as a mode plus elapsed-tick counters:
// the running frame is derived from ticks spent running, and the jump
// height from the closed-form ballistic sum k*V - k*(k-1)/2.
// -----------------------------------------------------------------------------
module tb_hero_anim_sequencer;

   localparam int RF = 5;
   localparam int TPF = 6;
   localparam int JV = 8;

   logic       vga_clk;
   logic       reset_n;
   logic       frame_tick;
   logic       move_left;
   logic       move_right;
   logic       jump_req;
   logic [2:0] sprite_sel;
   logic       facing_left;
   logic [6:0] y_offset;
   logic       airborne;

   hero_anim_sequencer #(
      .RUN_FRAMES      (RF),
      .TICKS_PER_FRAME (TPF),
      .JUMP_V          (JV)
   ) dut (
      .vga_clk     (vga_clk),
      .reset_n     (reset_n),
      .frame_tick  (frame_tick),
      .move_left   (move_left),
      .move_right  (move_right),
      .jump_req    (jump_req),
      .sprite_sel  (sprite_sel),
      .facing_left (facing_left),
      .y_offset    (y_offset),
      .airborne    (airborne)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: 0 idle, 1 run, 2 jump.
   int m_mode      = 0;
   int m_run_ticks = 0;   // ticks spent running since entering RUN
   int m_air_k     = 0;   // airborne ticks so far (1 on launch tick)
   int m_face      = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int jump_height(input int k);
      return k * JV - (k * (k - 1)) / 2;
   endfunction

   function automatic int exp_sprite();
      if (m_mode == 0) return 0;
      if (m_mode == 1) return 1 + (m_run_ticks / TPF) % RF;
      return 6;
   endfunction

   function automatic int exp_y();
      return (m_mode == 2) ? jump_height(m_air_k) : 0;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_run_ticks = 0; m_air_k = 0; m_face = 0;
   endtask

   task automatic model_tick(input bit ml, input bit mr, input bit jr);
      bit mv;
      mv = ml ^ mr;
      if (mv) m_face = ml;
      case (m_mode)
         0: begin
            if (jr) begin m_mode = 2; m_air_k = 1; end
            else if (mv) begin m_mode = 1; m_run_ticks = 0; end
         end
         1: begin
            if (jr) begin m_mode = 2; m_air_k = 1; end
            else if (!mv) m_mode = 0;
            else m_run_ticks++;
         end
         default: begin
            if (jump_height(m_air_k + 1) <= 0) begin
               m_mode = mv ? 1 : 0;
               m_run_ticks = 0;
            end else begin
               m_air_k++;
            end
         end
      endcase
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".sprite"}, int'(sprite_sel), exp_sprite());
      chk({tag, ".face"},   int'(facing_left), m_face);
      chk({tag, ".y"},      int'(y_offset), exp_y());
      chk({tag, ".air"},    int'(airborne), (m_mode == 2) ? 1 : 0);
   endtask

   // One frame: tick with the given inputs, check, then `gap` non-tick
   // cycles of random input noise which must not disturb the outputs.
   task automatic do_tick(input bit ml, input bit mr, input bit jr, input int gap);
      move_left = ml; move_right = mr; jump_req = jr;
      frame_tick = 1'b1;
      @(posedge vga_clk); #1;
      frame_tick = 1'b0;
      model_tick(ml, mr, jr);
      check_outputs("tick");
      for (int g = 0; g < gap; g++) begin
         move_left  = 1'($urandom);
         move_right = 1'($urandom);
         jump_req   = 1'($urandom);
         @(posedge vga_clk); #1;
         chk("hold.sprite", int'(sprite_sel), exp_sprite());
         chk("hold.y", int'(y_offset), exp_y());
      end
   endtask

   initial begin
      reset_n = 1'b0; frame_tick = 1'b0;
      move_left = 1'b0; move_right = 1'b0; jump_req = 1'b0;
      model_reset();
      repeat (3) @(posedge vga_clk);
      #1;
      check_outputs("reset");
      reset_n = 1'b1;
      @(posedge vga_clk); #1;

      // Idle ticks
      for (int i = 0; i < 3; i++) do_tick(0, 0, 0, 1);
      // Run right for 31 ticks, covering the wrap back to frame 1
      for (int i = 0; i < 31; i++) do_tick(0, 1, 0, 1);
      // Run left, release, then move again
      for (int i = 0; i < 8; i++) do_tick(1, 0, 0, 1);
      do_tick(0, 0, 0, 1);
      do_tick(1, 0, 0, 1);
      do_tick(0, 0, 0, 1);
      // Single jump pulse from idle, then wait through landing
      do_tick(0, 0, 1, 1);
      for (int i = 0; i < 17; i++) do_tick(0, 0, 0, 1);
      // Both directions while running
      for (int i = 0; i < 4; i++) do_tick(0, 1, 0, 1);
      do_tick(1, 1, 0, 1);
      // Held jump: no double jump, relaunch right after landing
      for (int i = 0; i < 20; i++) do_tick(0, 1, 1, 0);

      // Randomized frames
      for (int i = 0; i < 400; i++) begin
         do_tick(1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
                 $urandom_range(0, 3));
      end

      // Reset mid-jump at height 30
      for (int i = 0; i < 30 && m_mode != 0; i++) do_tick(0, 0, 0, 0);
      do_tick(0, 0, 1, 0);
      for (int i = 0; i < 20 && exp_y() != 30; i++) do_tick(0, 0, 0, 0);
      chk("pre_reset.y", int'(y_offset), 30);
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_reset");
      frame_tick = 1'b1; move_right = 1'b1; jump_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge vga_clk); #1;
         check_outputs("tick_in_reset");
      end
      frame_tick = 1'b0; jump_req = 1'b0; move_right = 1'b0;
      #2;
      reset_n = 1'b1;
      @(posedge vga_clk); #1;
      check_outputs("post_reset");
      do_tick(0, 1, 0, 1);
      do_tick(0, 0, 1, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
